// File: rtl/uart_pkg.sv
// Shared UART constants and FSM state encoding for the 9600-baud TX/RX pair.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_9600 = 5208;
  localparam int unsigned BAUD_CNT_W        = 13;
  localparam int unsigned FRAME_BITS        = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO: registered pointers/count, head shown on dout.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_9600.sv
// 8N1 UART transmitter: valid/ready byte intake into a FIFO, registered serial line.
module uart_tx_9600
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_9600,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam logic [BAUD_CNT_W-1:0] BIT_END = BAUD_CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e           state_q, state_d;
  logic [BAUD_CNT_W-1:0] baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  push_c;
  logic                  pop_c;
  logic                  bit_end_c;
  logic [7:0]            fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign push_c    = tx_valid && !fifo_full;
  assign bit_end_c = (baud_q == BIT_END);
  assign tx_ready  = !fifo_full;
  assign tx_busy   = (state_q != IDLE) || !fifo_empty;
  assign tx        = tx_q;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .din   (tx_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State, baud counter, bit index, shift register and line register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Frame sequencing; the line value is derived from the next state so tx stays registered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_c   = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = fifo_dout;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end_c) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end_c) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + BAUD_CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end_c) begin
          baud_d = '0;
          if (!fifo_empty) begin
            // Chain straight into the next start bit with no idle gap.
            pop_c   = 1'b1;
            shift_d = fifo_dout;
            bit_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_9600.sv
// Bench for uart_tx_9600: one instance at 9600-baud defaults, one at 16 clocks per bit.
module tb_uart_tx_9600;

  localparam int unsigned DFLT_CPB = 5208;
  localparam int unsigned FAST_CPB = 16;

  logic       clk;
  logic       rst;

  logic [7:0] d_data;
  logic       d_valid;
  logic       d_ready;
  logic       d_tx;
  logic       d_busy;
  logic [2:0] d_count;

  logic [7:0] f_data;
  logic       f_valid;
  logic       f_ready;
  logic       f_tx;
  logic       f_busy;
  logic [2:0] f_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx_q [$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs [6];

  uart_tx_9600 #(.CLKS_PER_BIT(DFLT_CPB), .FIFO_DEPTH(4)) dut_d (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (d_data),
    .tx_valid   (d_valid),
    .tx_ready   (d_ready),
    .tx         (d_tx),
    .tx_busy    (d_busy),
    .fifo_count (d_count)
  );

  uart_tx_9600 #(.CLKS_PER_BIT(FAST_CPB), .FIFO_DEPTH(4)) dut_f (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (f_data),
    .tx_valid   (f_valid),
    .tx_ready   (f_ready),
    .tx         (f_tx),
    .tx_busy    (f_busy),
    .fifo_count (f_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Hard stop if anything stalls.
  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at the negedge of the first start-bit cycle; checks every cycle of the frame.
  task automatic check_frame(input bit sel, input int unsigned cpb, input logic [9:0] exp,
                             input string tag);
    for (int j = 0; j < 10; j++) begin
      int errs;
      errs = 0;
      for (int c = 0; c < int'(cpb); c++) begin
        logic line;
        logic busy;
        line = sel ? d_tx : f_tx;
        busy = sel ? d_busy : f_busy;
        if (line !== exp[j] || busy !== 1'b1) errs++;
        @(negedge clk);
      end
      chk($sformatf("%s bit%0d", tag, j), 32'(errs), 32'd0);
    end
  endtask

  // Serial receiver model on the fast line: mid-bit sampling, 8N1.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && f_tx === 1'b0) begin
        logic [7:0] d;
        d = '0;
        repeat (FAST_CPB / 2) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
          repeat (FAST_CPB) @(negedge clk);
          d[b] = f_tx;
        end
        repeat (FAST_CPB) @(negedge clk);
        rx_q.push_back(d);
      end
    end
  end

  initial begin
    logic [7:0] bytes6 [6];
    int         acc [6];
    logic [2:0] cnt5;
    logic       rdy5;
    int         peak;
    int         e_tx, e_rdy, e_busy, e_cnt;

    vecs[0] = '{8'h34, 10'h268};
    vecs[1] = '{8'h38, 10'h270};
    vecs[2] = '{8'h32, 10'h264};
    vecs[3] = '{8'h00, 10'h200};
    vecs[4] = '{8'hFF, 10'h3FE};
    vecs[5] = '{8'hA5, 10'h34A};

    bytes6[0] = 8'h11; bytes6[1] = 8'h22; bytes6[2] = 8'h33;
    bytes6[3] = 8'h44; bytes6[4] = 8'h55; bytes6[5] = 8'h66;

    rst = 1'b1;
    d_data = '0; d_valid = 1'b0;
    f_data = '0; f_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state held for 20 cycles on both instances.
    e_tx = 0; e_rdy = 0; e_busy = 0; e_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d_tx !== 1'b1 || f_tx !== 1'b1) e_tx++;
      if (d_ready !== 1'b1 || f_ready !== 1'b1) e_rdy++;
      if (d_busy !== 1'b0 || f_busy !== 1'b0) e_busy++;
      if (d_count !== 3'd0 || f_count !== 3'd0) e_cnt++;
    end
    chk("reset tx", 32'(e_tx), 32'd0);
    chk("reset ready", 32'(e_rdy), 32'd0);
    chk("reset busy", 32'(e_busy), 32'd0);
    chk("reset count", 32'(e_cnt), 32'd0);

    // Single byte at default baud: latency, bit timing, busy drop.
    d_data = 8'h34; d_valid = 1'b1;
    chk("dflt ready before push", 32'(d_ready), 32'd1);
    @(negedge clk);
    d_valid = 1'b0;
    chk("dflt tx before pop", 32'(d_tx), 32'd1);
    chk("dflt count after push", 32'(d_count), 32'd1);
    chk("dflt busy after push", 32'(d_busy), 32'd1);
    @(negedge clk);
    chk("dflt count after pop", 32'(d_count), 32'd0);
    check_frame(1'b1, DFLT_CPB, 10'h268, "dflt 34");
    chk("dflt busy after frame", 32'(d_busy), 32'd0);
    chk("dflt tx after frame", 32'(d_tx), 32'd1);

    // Table of single frames on the fast instance.
    rx_q.delete();
    for (int v = 0; v < 6; v++) begin
      f_data = vecs[v].data; f_valid = 1'b1;
      @(negedge clk);
      f_valid = 1'b0;
      @(negedge clk);
      check_frame(1'b0, FAST_CPB, vecs[v].frame, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d idle busy", v), 32'(f_busy), 32'd0);
    end
    chk("table rx count", 32'(rx_q.size()), 32'd6);
    for (int v = 0; v < 6 && v < rx_q.size(); v++)
      chk($sformatf("table rx byte%0d", v), 32'(rx_q[v]), 32'(vecs[v].data));

    // "482" pushed back to back: count peak and contiguous frames.
    rx_q.delete();
    f_data = 8'h34; f_valid = 1'b1;
    fork
      begin
        @(negedge clk);
        chk("482 count t1", 32'(f_count), 32'd1);
        chk("482 tx t1", 32'(f_tx), 32'd1);
        f_data = 8'h38;
        @(negedge clk);
        chk("482 count t2", 32'(f_count), 32'd1);
        f_data = 8'h32;
        @(negedge clk);
        f_valid = 1'b0;
        peak = int'(f_count);
        for (int i = 0; i < 470; i++) begin
          @(negedge clk);
          if (int'(f_count) > peak) peak = int'(f_count);
        end
        chk("482 count peak", 32'(peak), 32'd2);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        check_frame(1'b0, FAST_CPB, 10'h268, "482 f0");
        check_frame(1'b0, FAST_CPB, 10'h270, "482 f1");
        check_frame(1'b0, FAST_CPB, 10'h264, "482 f2");
      end
    join
    chk("482 busy end", 32'(f_busy), 32'd0);
    chk("482 tx end", 32'(f_tx), 32'd1);
    chk("482 rx count", 32'(rx_q.size()), 32'd3);
    if (rx_q.size() == 3) begin
      chk("482 rx0", 32'(rx_q[0]), 32'h34);
      chk("482 rx1", 32'(rx_q[1]), 32'h38);
      chk("482 rx2", 32'(rx_q[2]), 32'h32);
    end
    repeat (4) @(negedge clk);

    // Six bytes with valid held: backpressure when full, order preserved.
    cnt5 = '0; rdy5 = 1'b1;
    f_data = bytes6[0]; f_valid = 1'b1;
    fork
      begin
        int t;
        t = 0;
        for (int i = 0; i < 6; i++) begin
          int guard;
          guard = 0;
          while (f_ready !== 1'b1 && guard < 400) begin
            @(negedge clk);
            t++;
            guard++;
          end
          acc[i] = t;
          @(negedge clk);
          t++;
          if (i < 5) f_data = bytes6[i+1];
          else       f_valid = 1'b0;
        end
      end
      begin
        repeat (5) @(negedge clk);
        cnt5 = f_count;
        rdy5 = f_ready;
      end
      begin
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 6; i++)
          check_frame(1'b0, FAST_CPB, {1'b1, bytes6[i], 1'b0}, $sformatf("six f%0d", i));
      end
    join
    f_valid = 1'b0;
    chk("six count when full", 32'(cnt5), 32'd4);
    chk("six ready when full", 32'(rdy5), 32'd0);
    chk("six accept b4", 32'(acc[4]), 32'd4);
    chk("six accept b5", 32'(acc[5]), 32'd162);
    chk("six busy end", 32'(f_busy), 32'd0);
    repeat (4) @(negedge clk);

    // Reset during data bit 3 of 0x55 with two bytes queued.
    f_data = 8'h55; f_valid = 1'b1;
    @(negedge clk);
    f_data = 8'hAA;
    @(negedge clk);
    f_data = 8'h0F;
    @(negedge clk);
    f_valid = 1'b0;
    repeat (70) @(negedge clk);
    chk("rst pre tx bit3", 32'(f_tx), 32'd0);
    chk("rst pre count", 32'(f_count), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst tx", 32'(f_tx), 32'd1);
    chk("rst count", 32'(f_count), 32'd0);
    chk("rst ready", 32'(f_ready), 32'd1);
    chk("rst busy", 32'(f_busy), 32'd0);
    e_tx = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (f_tx !== 1'b1 || f_busy !== 1'b0) e_tx++;
    end
    chk("rst quiet line", 32'(e_tx), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_9600.md
# uart_tx_9600

Serial UART transmitter that sources the `rx` line consumed by the existing 9600-baud receiver. Accepts bytes over a valid/ready handshake into a small FIFO and serialises them as 8N1 frames (start, 8 data bits LSB first, one stop bit) at CLKS_PER_BIT system clocks per bit. Sits between on-chip byte producers and the board TX pin, and closes the loopback path to the receiver.

## Interface
- CLKS_PER_BIT, 5208, system clocks per bit; 50 MHz / 9600 baud gives 104160 ns per bit; legal range 4..8191.
- FIFO_DEPTH, 4, byte buffer entries; power of two, 2..16.
- clk  in  1  system clock, 50 MHz, single clock domain.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to send.
- tx_valid  in  1  producer offers tx_data.
- tx_ready  out  1  FIFO can accept; transfer occurs on any edge with tx_valid && tx_ready.
- tx  out  1  serial line, idle high.
- tx_busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes currently buffered.

## Operation
- Reset values: tx=1, tx_ready=1, tx_busy=0, fifo_count=0; FSM in IDLE; FIFO pointers, baud counter and bit index cleared.
- tx_ready = (fifo_count != FIFO_DEPTH); it is combinational from registered count only and never depends on tx_valid.
- Push when full is impossible: tx_ready is low. A pop in the same cycle does not open ready; acceptance resumes the next cycle.
- FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. At each bit end, shift right and increment the index. After bit 7 ends, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START, giving no gap between frames. Otherwise go to IDLE.
- Baud counter is 13 bits and counts 0..CLKS_PER_BIT-1. Bit end is the cycle where the counter equals CLKS_PER_BIT-1; the counter wraps to 0 on that cycle.
- tx is driven from a register; there are no combinational paths to the pin.
- A push during a frame never disturbs the frame in progress.
- Reset asserted mid-frame: on the next edge tx=1, the frame is abandoned and the FIFO is emptied. There is no partial-stop completion.
- tx_data is held as in the FIFO entry; the producer may change it after the handshake.

## Timing
- Latency, idle with empty FIFO: a handshake at edge k writes the FIFO. At edge k+1 IDLE pops and tx falls, so the first start-bit cycle is k+1..k+CLKS_PER_BIT.
- Frame length is exactly 10*CLKS_PER_BIT cycles: 52080 cycles, 1.0416 ms at defaults.
- Back-to-back frames: the next start bit begins the cycle after the previous stop bit's last cycle.
- fifo_count updates the cycle after a push or pop. A simultaneous push and pop leaves the count unchanged.
- tx_busy drops in the first IDLE cycle with an empty FIFO.

## Structure
- Shared package uart_pkg:
  - CLKS_PER_BIT_9600 = 5208.
  - BAUD_CNT_W = 13.
  - State enum {IDLE, START, DATA, STOP}.
  - FRAME_BITS = 10.
- The receiver uses the same package constants.
- Sub-module uart_tx_fifo: synchronous FIFO with push, pop, din, dout, count, full and empty. It has registered pointers and shows the head on dout combinationally.
- The FSM, baud counter and shift register live in the top of this block.

## Test plan
- After reset hold 20 cycles: tx=1, tx_ready=1, tx_busy=0, fifo_count=0 throughout.
- Push 0x34 at defaults: tx falls one edge after the handshake. Line sequence at 104160 ns per bit is 0, then 0 0 1 0 1 1 0 0, then 1. tx_busy falls after 52080 cycles.
- Push 0x34, 0x38, 0x32 (ASCII "482") in consecutive cycles with CLKS_PER_BIT=16:
  - fifo_count peaks at 2 (the first byte is popped immediately).
  - Three frames run contiguously, 480 cycles total, with no idle cycle between them.
- Push 6 bytes with tx_valid held high and CLKS_PER_BIT=16:
  - tx_ready drops when fifo_count reaches 4.
  - Each subsequent byte is accepted only after a pop.
  - The stream order matches the push order.
- Assert rst during data bit 3 of 0x55 with 2 bytes queued: next edge tx=1, fifo_count=0, tx_ready=1. No further line activity.
- Loopback: connect tx to the receiver's rx at default baud and send 0x34, 0x38, 0x32. The receiver's byte output shows 0x34, 0x38, 0x32 in order.
